// File: rtl/toll_lane_ctrl.sv
// Toll lane controller: detects a new vehicle, requests a rate lookup, collects
// payment, then opens the gate or flags a violation until the exit loop clears.
module toll_lane_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vehicle_i,
   input  logic [2:0]  axles_i,
   input  logic [12:0] clock_i,
   output logic        rate_req_o,
   output logic [2:0]  rate_axles_o,
   output logic [12:0] rate_clock_o,
   input  logic        rate_valid_i,
   input  logic [15:0] rate_toll_i,
   input  logic        pay_valid_i,
   input  logic [15:0] pay_cents_i,
   input  logic        exit_i,
   output logic [15:0] amount_due_o,
   output logic [15:0] change_o,
   output logic        go_o,
   output logic        stop_o,
   output logic        violation_o,
   output logic [7:0]  viol_count_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WAIT_PAY, S_OPEN, S_VIOL
   } state_e;

   localparam logic [11:0] LOOKUP_LIMIT = 12'd16;
   localparam logic [11:0] PAY_LIMIT    = 12'd4095;

   state_e      state_q, state_d;
   logic        veh_prev_q;
   logic [2:0]  axles_q, axles_d;
   logic [12:0] clock_q, clock_d;
   logic        rate_req_q, rate_req_d;
   logic [15:0] toll_q, toll_d;
   logic [16:0] paid_q, paid_d;
   logic [11:0] timer_q, timer_d;
   logic [15:0] due_q, due_d;
   logic [15:0] change_q, change_d;
   logic        viol_q, viol_d;
   logic [7:0]  vcount_q, vcount_d;
   logic        go_q, stop_q, busy_q;

   logic        veh_rise;
   logic        axles_ok;
   logic [17:0] paid_sum;
   logic [16:0] paid_new;
   logic [11:0] timer_inc;

   assign veh_rise  = vehicle_i & ~veh_prev_q;
   assign axles_ok  = (axles_i >= 3'd2) && (axles_i <= 3'd4);
   assign paid_sum  = {1'b0, paid_q} + {2'b00, pay_cents_i};
   assign paid_new  = paid_sum[17] ? 17'h1FFFF : paid_sum[16:0];
   assign timer_inc = timer_q + 12'd1;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      axles_d    = axles_q;
      clock_d    = clock_q;
      rate_req_d = 1'b0;
      toll_d     = toll_q;
      paid_d     = paid_q;
      timer_d    = timer_q;
      due_d      = due_q;
      change_d   = change_q;
      viol_d     = 1'b0;
      vcount_d   = vcount_q;

      case (state_q)
         S_IDLE: begin
            if (veh_rise) begin
               axles_d = axles_i;
               clock_d = clock_i;
               timer_d = '0;
               if (axles_ok) begin
                  rate_req_d = 1'b1;
                  state_d    = S_LOOKUP;
               end else begin
                  state_d    = S_VIOL;
               end
            end
         end
         S_LOOKUP: begin
            if (rate_valid_i) begin
               toll_d   = rate_toll_i;
               due_d    = rate_toll_i;
               paid_d   = '0;
               timer_d  = '0;
               change_d = '0;
               state_d  = (rate_toll_i == 16'd0) ? S_OPEN : S_WAIT_PAY;
            end else begin
               timer_d = timer_inc;
               if (timer_inc == LOOKUP_LIMIT) state_d = S_VIOL;
            end
         end
         S_WAIT_PAY: begin
            // Driving through beats any payment landing in the same cycle.
            if (exit_i) begin
               state_d = S_VIOL;
            end else if (pay_valid_i) begin
               paid_d  = paid_new;
               timer_d = '0;
               if (paid_new >= {1'b0, toll_q}) begin
                  due_d    = '0;
                  change_d = paid_new[15:0] - toll_q;
                  state_d  = S_OPEN;
               end else begin
                  due_d    = toll_q - paid_new[15:0];
               end
            end else begin
               timer_d = timer_inc;
               if (timer_inc == PAY_LIMIT) state_d = S_VIOL;
            end
         end
         S_OPEN, S_VIOL: begin
            if (exit_i) begin
               due_d    = '0;
               change_d = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_VIOL && state_q != S_VIOL) begin
         viol_d   = 1'b1;
         vcount_d = (vcount_q == 8'hFF) ? vcount_q : vcount_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         veh_prev_q <= 1'b1;   // a vehicle already present at reset release is not a new arrival
         axles_q    <= '0;
         clock_q    <= '0;
         rate_req_q <= 1'b0;
         toll_q     <= '0;
         paid_q     <= '0;
         timer_q    <= '0;
         due_q      <= '0;
         change_q   <= '0;
         viol_q     <= 1'b0;
         vcount_q   <= '0;
         go_q       <= 1'b0;
         stop_q     <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         veh_prev_q <= vehicle_i;
         axles_q    <= axles_d;
         clock_q    <= clock_d;
         rate_req_q <= rate_req_d;
         toll_q     <= toll_d;
         paid_q     <= paid_d;
         timer_q    <= timer_d;
         due_q      <= due_d;
         change_q   <= change_d;
         viol_q     <= viol_d;
         vcount_q   <= vcount_d;
         go_q       <= (state_d == S_OPEN);
         stop_q     <= (state_d != S_OPEN);
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign rate_req_o   = rate_req_q;
   assign rate_axles_o = axles_q;
   assign rate_clock_o = clock_q;
   assign amount_due_o = due_q;
   assign change_o     = change_q;
   assign go_o         = go_q;
   assign stop_o       = stop_q;
   assign violation_o  = viol_q;
   assign viol_count_o = vcount_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_toll_lane_ctrl.sv
// Directed bench for toll_lane_ctrl: each task drives one scenario and checks
// the registered outputs at the falling edge against hand-computed values.
module tb_toll_lane_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        vehicle_i = 1'b0;
   logic [2:0]  axles_i = '0;
   logic [12:0] clock_i = '0;
   logic        rate_req_o;
   logic [2:0]  rate_axles_o;
   logic [12:0] rate_clock_o;
   logic        rate_valid_i = 1'b0;
   logic [15:0] rate_toll_i = '0;
   logic        pay_valid_i = 1'b0;
   logic [15:0] pay_cents_i = '0;
   logic        exit_i = 1'b0;
   logic [15:0] amount_due_o;
   logic [15:0] change_o;
   logic        go_o, stop_o, violation_o, busy_o;
   logic [7:0]  viol_count_o;

   int checks = 0;
   int errors = 0;
   int vexp   = 0;

   toll_lane_ctrl dut (
      .clk(clk), .rst_n(rst_n), .vehicle_i(vehicle_i), .axles_i(axles_i),
      .clock_i(clock_i), .rate_req_o(rate_req_o), .rate_axles_o(rate_axles_o),
      .rate_clock_o(rate_clock_o), .rate_valid_i(rate_valid_i),
      .rate_toll_i(rate_toll_i), .pay_valid_i(pay_valid_i),
      .pay_cents_i(pay_cents_i), .exit_i(exit_i), .amount_due_o(amount_due_o),
      .change_o(change_o), .go_o(go_o), .stop_o(stop_o),
      .violation_o(violation_o), .viol_count_o(viol_count_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // {go, stop, busy, rate_req, violation}
   function automatic logic [4:0] flags();
      return {go_o, stop_o, busy_o, rate_req_o, violation_o};
   endfunction

   task automatic start_vehicle(input logic [2:0] ax, input logic [12:0] mn);
      vehicle_i = 1'b1; axles_i = ax; clock_i = mn;
      tick();
   endtask

   task automatic leave();
      exit_i = 1'b1; vehicle_i = 1'b0;
      tick();
      exit_i = 1'b0;
   endtask

   task automatic test_reset();
      vehicle_i = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (flags() !== 5'b01000) begin errors++; $display("FAIL reset_flags got %b want 01000", flags()); end
      checks++; if ({amount_due_o, change_o, viol_count_o} !== 40'd0) begin errors++; $display("FAIL reset_values due %0d change %0d vcount %0d want 0", amount_due_o, change_o, viol_count_o); end
      checks++; if ({rate_axles_o, rate_clock_o} !== 16'd0) begin errors++; $display("FAIL reset_latches axles %0d clock %0d want 0", rate_axles_o, rate_clock_o); end
      @(negedge clk) rst_n = 1'b1;
      tick(3);
      checks++; if (flags() !== 5'b01000) begin errors++; $display("FAIL reset_high_vehicle got %b want 01000", flags()); end
      vehicle_i = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      start_vehicle(3'd2, 13'd480);
      checks++; if (flags() !== 5'b01110) begin errors++; $display("FAIL basic_req got %b want 01110", flags()); end
      checks++; if (rate_axles_o !== 3'd2 || rate_clock_o !== 13'd480) begin errors++; $display("FAIL basic_latch got %0d/%0d want 2/480", rate_axles_o, rate_clock_o); end
      rate_valid_i = 1'b1; rate_toll_i = 16'd90;
      tick();
      rate_valid_i = 1'b0;
      checks++; if (amount_due_o !== 16'd90 || flags() !== 5'b01100) begin errors++; $display("FAIL basic_due got %0d %b want 90 01100", amount_due_o, flags()); end
      pay_valid_i = 1'b1; pay_cents_i = 16'd100;
      tick();
      pay_valid_i = 1'b0;
      checks++; if (flags() !== 5'b10100 || change_o !== 16'd10 || amount_due_o !== 16'd0) begin errors++; $display("FAIL basic_open got %b change %0d due %0d want 10100 10 0", flags(), change_o, amount_due_o); end
      tick(4);
      checks++; if (go_o !== 1'b1 || rate_axles_o !== 3'd2) begin errors++; $display("FAIL basic_hold go %0b axles %0d want 1 2", go_o, rate_axles_o); end
      leave();
      checks++; if (flags() !== 5'b01000 || change_o !== 16'd0) begin errors++; $display("FAIL basic_idle got %b change %0d want 01000 0", flags(), change_o); end
   endtask

   task automatic test_multi_pay();
      start_vehicle(3'd4, 13'd1439);
      checks++; if (rate_clock_o !== 13'd1439 || rate_req_o !== 1'b1) begin errors++; $display("FAIL multi_req clock %0d req %0b want 1439 1", rate_clock_o, rate_req_o); end
      pay_valid_i = 1'b1; pay_cents_i = 16'd500;
      tick();
      pay_valid_i = 1'b0;
      rate_valid_i = 1'b1; rate_toll_i = 16'd195;
      tick();
      rate_valid_i = 1'b0;
      checks++; if (amount_due_o !== 16'd195) begin errors++; $display("FAIL multi_ignore_pay got %0d want 195", amount_due_o); end
      pay_valid_i = 1'b1; pay_cents_i = 16'd100;
      tick();
      checks++; if (amount_due_o !== 16'd95) begin errors++; $display("FAIL multi_due95 got %0d want 95", amount_due_o); end
      pay_cents_i = 16'd50;
      tick();
      checks++; if (amount_due_o !== 16'd45) begin errors++; $display("FAIL multi_due45 got %0d want 45", amount_due_o); end
      pay_cents_i = 16'd45;
      tick();
      pay_valid_i = 1'b0;
      checks++; if (flags() !== 5'b10100 || change_o !== 16'd0 || amount_due_o !== 16'd0) begin errors++; $display("FAIL multi_exact got %b change %0d due %0d want 10100 0 0", flags(), change_o, amount_due_o); end
      rate_valid_i = 1'b1; rate_toll_i = 16'd777;
      tick();
      rate_valid_i = 1'b0;
      checks++; if (go_o !== 1'b1 || amount_due_o !== 16'd0) begin errors++; $display("FAIL multi_ignore_rate go %0b due %0d want 1 0", go_o, amount_due_o); end
      leave();
   endtask

   task automatic test_bad_axles();
      start_vehicle(3'd5, 13'd100);
      vexp++;
      checks++; if (flags() !== 5'b01101 || viol_count_o !== 8'(vexp)) begin errors++; $display("FAIL axles_viol got %b vcount %0d want 01101 %0d", flags(), viol_count_o, vexp); end
      tick(5);
      checks++; if (flags() !== 5'b01100) begin errors++; $display("FAIL axles_stop got %b want 01100", flags()); end
      leave();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL axles_idle busy %0b want 0", busy_o); end
   endtask

   task automatic test_lookup_timeout();
      logic early = 1'b0;
      start_vehicle(3'd3, 13'd600);
      for (int i = 0; i < 15; i++) begin
         tick();
         early = early | violation_o;
      end
      checks++; if (early !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL lookup_early viol %0b busy %0b want 0 1", early, busy_o); end
      tick();
      vexp++;
      checks++; if (violation_o !== 1'b1 || viol_count_o !== 8'(vexp)) begin errors++; $display("FAIL lookup_timeout viol %0b vcount %0d want 1 %0d", violation_o, viol_count_o, vexp); end
      leave();
   endtask

   task automatic test_zero_toll_late();
      start_vehicle(3'd2, 13'd10);
      tick(15);
      rate_valid_i = 1'b1; rate_toll_i = 16'd0;
      tick();
      rate_valid_i = 1'b0;
      checks++; if (flags() !== 5'b10100 || change_o !== 16'd0) begin errors++; $display("FAIL zero_toll got %b change %0d want 10100 0", flags(), change_o); end
      leave();
   endtask

   task automatic test_pay_timeout();
      logic early = 1'b0;
      start_vehicle(3'd2, 13'd700);
      rate_valid_i = 1'b1; rate_toll_i = 16'd50;
      tick();
      rate_valid_i = 1'b0;
      tick(100);
      pay_valid_i = 1'b1; pay_cents_i = 16'd20;
      tick();
      pay_valid_i = 1'b0;
      for (int i = 0; i < 4094; i++) begin
         tick();
         early = early | violation_o;
      end
      checks++; if (early !== 1'b0 || amount_due_o !== 16'd30) begin errors++; $display("FAIL pay_early viol %0b due %0d want 0 30", early, amount_due_o); end
      tick();
      vexp++;
      checks++; if (flags() !== 5'b01101 || viol_count_o !== 8'(vexp)) begin errors++; $display("FAIL pay_timeout got %b vcount %0d want 01101 %0d", flags(), viol_count_o, vexp); end
      leave();
   endtask

   task automatic test_exit_priority();
      start_vehicle(3'd3, 13'd800);
      rate_valid_i = 1'b1; rate_toll_i = 16'd60;
      tick();
      rate_valid_i = 1'b0;
      exit_i = 1'b1; pay_valid_i = 1'b1; pay_cents_i = 16'd100;
      tick();
      pay_valid_i = 1'b0;
      vexp++;
      checks++; if (flags() !== 5'b01101 || viol_count_o !== 8'(vexp)) begin errors++; $display("FAIL exit_prio got %b vcount %0d want 01101 %0d", flags(), viol_count_o, vexp); end
      tick();
      checks++; if (flags() !== 5'b01000) begin errors++; $display("FAIL exit_idle got %b want 01000", flags()); end
      exit_i = 1'b0; vehicle_i = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      while (vexp < 258) begin
         start_vehicle(3'd0, 13'd0);
         vexp++;
         if (vexp == 255) begin
            checks++; if (viol_count_o !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", viol_count_o); end
         end
         leave();
      end
      start_vehicle(3'd7, 13'd0);
      checks++; if (viol_count_o !== 8'd255 || violation_o !== 1'b1) begin errors++; $display("FAIL sat_hold vcount %0d viol %0b want 255 1", viol_count_o, violation_o); end
      leave();
   endtask

   task automatic test_reset_mid();
      logic pulse = 1'b0;
      start_vehicle(3'd2, 13'd900);
      rate_valid_i = 1'b1; rate_toll_i = 16'd80;
      tick();
      rate_valid_i = 1'b0;
      pay_valid_i = 1'b1; pay_cents_i = 16'd30;
      tick();
      pay_valid_i = 1'b0;
      checks++; if (amount_due_o !== 16'd50) begin errors++; $display("FAIL mid_due got %0d want 50", amount_due_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (flags() !== 5'b01000 || {amount_due_o, change_o, viol_count_o} !== 40'd0) begin errors++; $display("FAIL mid_reset got %b due %0d vcount %0d want 01000 0 0", flags(), amount_due_o, viol_count_o); end
      vehicle_i = 1'b0; exit_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         pulse = pulse | violation_o;
      end
      rst_n = 1'b1; exit_i = 1'b0;
      tick(2);
      pulse = pulse | violation_o;
      checks++; if (pulse !== 1'b0 || viol_count_o !== 8'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_noviol pulse %0b vcount %0d busy %0b want 0 0 0", pulse, viol_count_o, busy_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi_pay();
      test_bad_axles();
      test_lookup_timeout();
      test_zero_toll_late();
      test_pay_timeout();
      test_exit_priority();
      test_saturation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
